// File: rtl/lb_sched_if.sv
// Pixel-in / window-out handshake bundle between the frame scheduler and its neighbours.
interface lb_sched_if #(
    parameter int unsigned DW = 8
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_ready;
    logic          lb_wen;
    logic [DW-1:0] lb_wdata;
    logic          lb_valid;
    logic          out_valid;
    logic          out_sof;
    logic          out_eol;
    logic          out_eof;

    modport slave (
        input  in_valid, in_data, out_ready, lb_valid,
        output in_ready, lb_wen, lb_wdata, out_valid, out_sof, out_eol, out_eof
    );

    modport master (
        output in_valid, in_data, out_ready, lb_valid,
        input  in_ready, lb_wen, lb_wdata, out_valid, out_sof, out_eol, out_eof
    );
endinterface

// File: rtl/lb_sched.sv
// Frame scheduler for the sliding-window line buffer: accepts one raster frame per start pulse.
// Optional LB_SCHED_STATS_EN adds a saturating stall_cnt output.
module lb_sched #(
    parameter int unsigned DW    = 8,
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 48,
    parameter int unsigned WIN   = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       start,
    lb_sched_if.slave  bus,
    output logic       busy,
    output logic       done
`ifdef LB_SCHED_STATS_EN
    ,
    output logic [15:0] stall_cnt
`endif
);
    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] C_COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] C_COL_WIN  = CW'(WIN - 1);
    localparam logic [RW-1:0] C_ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          w_in_ready;
    logic          w_acc;
    logic          w_col_last;
    logic          w_row_last;
    logic          w_frame_end;
    logic          w_col_ok;
    logic          w_out_valid;

    assign w_col_last  = (r_col == C_COL_LAST);
    assign w_row_last  = (r_row == C_ROW_LAST);
    assign w_frame_end = w_col_last & w_row_last;

    // Leading WIN-1 columns of each row hold cross-row or stale taps.
    if (WIN == 1) begin : g_nomask
        assign w_col_ok = 1'b1;
    end else begin : g_mask
        assign w_col_ok = (r_col >= C_COL_WIN);
    end

    assign w_in_ready  = ~RESET & ((r_state == S_FILL) | (r_state == S_RUN)) & bus.out_ready;
    assign w_acc       = bus.in_valid & w_in_ready;
    assign w_out_valid = w_acc & bus.lb_valid & w_col_ok;

    assign bus.in_ready  = w_in_ready;
    assign bus.lb_wen    = w_acc;
    assign bus.lb_wdata  = bus.in_data;
    assign bus.out_valid = w_out_valid;
    assign bus.out_sof   = w_out_valid & (r_row == '0) & (r_col == C_COL_WIN);
    assign bus.out_eol   = w_out_valid & w_col_last;
    assign bus.out_eof   = w_out_valid & w_frame_end;
    assign busy          = ~RESET & (r_state != S_IDLE);
    assign done          = ~RESET & (r_state == S_DONE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (WIN == 1) ? S_RUN : S_FILL;
                end
            end
            S_FILL: begin
                if (w_acc) begin
                    if (w_frame_end) begin
                        w_state_nxt = S_DONE;
                    end else if ((r_row == '0) && (r_col == C_COL_WIN)) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_acc && w_frame_end) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Raster position; the row wraps explicitly since IMG_H need not be a power of two.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

`ifdef LB_SCHED_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_stall_cnt <= '0;
        end else if (busy && bus.in_valid && !w_in_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_lb_sched.sv
// Randomised scoreboard bench for lb_sched: frame model in the driver, window checker on negedge.
`timescale 1ns/1ps
module tb_lb_sched;
    localparam int unsigned DW   = 8;
    localparam int unsigned W    = 16;
    localparam int unsigned H    = 2;
    localparam int unsigned WN   = 8;
    localparam int          NPIX = W * H;
    localparam int P_IDLE = 0;
    localparam int P_ACT  = 1;
    localparam int P_DONE = 2;

    typedef struct packed {
        logic          sof;
        logic          eol;
        logic          eof;
        logic [DW-1:0] data;
    } win_t;

    logic clk = 1'b0;
    logic RESET = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic busy_a, done_a, busy_b, done_b;
`ifdef LB_SCHED_STATS_EN
    logic [15:0] stall_a, stall_b;
`endif

    always #5 clk = ~clk;

    lb_sched_if #(.DW(DW)) ifa ();
    lb_sched_if #(.DW(DW)) ifb ();

    lb_sched #(.DW(DW), .IMG_W(W), .IMG_H(H), .WIN(WN)) dut_a (
        .CLK(clk), .RESET(RESET), .start(start_a), .bus(ifa.slave),
        .busy(busy_a), .done(done_a)
`ifdef LB_SCHED_STATS_EN
        , .stall_cnt(stall_a)
`endif
    );

    lb_sched #(.DW(DW), .IMG_W(4), .IMG_H(1), .WIN(1)) dut_b (
        .CLK(clk), .RESET(RESET), .start(start_b), .bus(ifb.slave),
        .busy(busy_b), .done(done_b)
`ifdef LB_SCHED_STATS_EN
        , .stall_cnt(stall_b)
`endif
    );

    int   n_vec = 0;
    int   n_err = 0;
    win_t sb_q[$];
    int   mon_win, mon_sof, mon_eol, mon_eof;

    // frame-level reference state
    int          phase = P_IDLE;
    int          pix   = 0;
    int          nwr   = 0;
    bit          p_rst = 1'b1, p_start, p_acc, p_last, p_stall;
    int unsigned m_stall = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ifa.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_window", {29'd0, ifa.out_sof, ifa.out_eol, ifa.out_eof}, 32'hFFFF_FFFF);
            end else begin
                win_t e;
                e = sb_q.pop_front();
                check("win_flags", {29'd0, ifa.out_sof, ifa.out_eol, ifa.out_eof},
                      {29'd0, e.sof, e.eol, e.eof});
                check("win_data", 32'(ifa.lb_wdata), 32'(e.data));
                mon_win++;
                mon_sof += int'(ifa.out_sof);
                mon_eol += int'(ifa.out_eol);
                mon_eof += int'(ifa.out_eof);
            end
        end
    end

    task automatic do_cycle(input bit st, input bit rst, input bit iv, input bit ordy, input bit lbk);
        bit e_busy, e_done, e_rdy, e_acc;
        int col, row;
        @(posedge clk);
        #1;
        if (p_rst) m_stall = 0;
        else if (phase == P_IDLE && p_start) m_stall = 0;
        else if (p_stall && m_stall < 65535) m_stall++;
        if (p_rst) begin
            phase = P_IDLE;
            pix   = 0;
        end else begin
            case (phase)
                P_IDLE: if (p_start) phase = P_ACT;
                P_ACT:  if (p_acc && p_last) phase = P_DONE;
                default: phase = P_IDLE;
            endcase
        end
        start_a      = st;
        RESET        = rst;
        ifa.in_valid = iv;
        ifa.in_data  = DW'($urandom);
        ifa.out_ready = ordy;
        ifa.lb_valid = lbk && (nwr >= int'(WN) - 1);
        #1;
        e_busy = !rst && phase != P_IDLE;
        e_done = !rst && phase == P_DONE;
        e_rdy  = !rst && phase == P_ACT && ordy;
        e_acc  = e_rdy && iv;
        check("busy", 32'(busy_a), 32'(e_busy));
        check("done", 32'(done_a), 32'(e_done));
        check("in_ready", 32'(ifa.in_ready), 32'(e_rdy));
        check("lb_wen", 32'(ifa.lb_wen), 32'(e_acc));
        check("sb_drain", sb_q.size(), 0);
        if (e_acc) check("lb_wdata", 32'(ifa.lb_wdata), 32'(ifa.in_data));
`ifdef LB_SCHED_STATS_EN
        check("stall_cnt", 32'(stall_a), m_stall);
`endif
        p_last = 1'b0;
        if (e_acc) begin
            col = pix % W;
            row = pix / W;
            if (col >= int'(WN) - 1 && ifa.lb_valid) begin
                win_t e;
                e.sof  = (row == 0) && (col == int'(WN) - 1);
                e.eol  = (col == int'(W) - 1);
                e.eof  = (col == int'(W) - 1) && (row == int'(H) - 1);
                e.data = ifa.in_data;
                sb_q.push_back(e);
            end
            p_last = (pix == NPIX - 1);
            pix    = p_last ? 0 : pix + 1;
            nwr++;
        end
        p_rst   = rst;
        p_start = st;
        p_acc   = e_acc;
        p_stall = e_busy && iv && !e_rdy;
    endtask

    // mode 1 continuous, 2 stall at row1 col10 plus stray starts, 3 long stall, 0 random
    task automatic run_frame(input int mode);
        int g = 0, hold = 0, stalls = 0;
        bit st, iv, ordy, lbk, chk300 = 1'b0;
        mon_win = 0; mon_sof = 0; mon_eol = 0; mon_eof = 0;
        do_cycle(1'b1, 1'b0, 1'($urandom_range(1)), 1'b1, 1'b1);
        while (phase != P_DONE && g < 3000) begin
            st = 1'b0; iv = 1'b1; ordy = 1'b1; lbk = 1'b1;
            case (mode)
                1: ;
                2: begin
                    if (pix == int'(W) + 10 && hold < 5) begin
                        ordy = 1'b0;
                        hold++;
                    end
                    st = ($urandom_range(4) == 0) || (p_acc && p_last);
                end
                3: begin
                    if (stalls < 300) begin
                        ordy = 1'b0;
                        stalls++;
                    end
                end
                default: begin
                    iv   = ($urandom_range(3) != 0);
                    ordy = ($urandom_range(3) != 0);
                    lbk  = ($urandom_range(7) != 0);
                    st   = ($urandom_range(5) == 0);
                end
            endcase
            do_cycle(st, 1'b0, iv, ordy, lbk);
            g++;
`ifdef LB_SCHED_STATS_EN
            if (mode == 3 && stalls == 300 && !chk300 && ordy) begin
                check("stall_300", 32'(stall_a), 32'd300);
                chk300 = 1'b1;
            end
`endif
        end
        check("frame_timeout", 32'(g < 3000), 32'd1);
        if (mode == 1 || mode == 2) begin
            check("win_count", mon_win, 18);
            check("sof_count", mon_sof, 1);
            check("eol_count", mon_eol, 2);
            check("eof_count", mon_eof, 1);
        end
        do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b0; ifa.lb_valid = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b0; ifb.lb_valid = 1'b0;

        do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // reset in the middle of a frame, then a clean frame over stale buffer contents
        do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        run_frame(1);
        run_frame(2);
        run_frame(3);
        run_frame(1);
        for (int f = 0; f < 5; f++) run_frame(0);

        // WIN=1 instance: no masking and no fill phase
        @(posedge clk); #1;
        start_b = 1'b1; ifb.in_valid = 1'b1; ifb.out_ready = 1'b1; ifb.lb_valid = 1'b1;
        #1;
        check("b_idle_rdy", 32'(ifb.in_ready), 32'd0);
        check("b_idle_busy", 32'(busy_b), 32'd0);
        for (int p = 0; p < 4; p++) begin
            @(posedge clk); #1;
            start_b = (p == 2);
            ifb.in_data = DW'(p + 1);
            #1;
            check("b_busy", 32'(busy_b), 32'd1);
            check("b_rdy", 32'(ifb.in_ready), 32'd1);
            check("b_valid", 32'(ifb.out_valid), 32'd1);
            check("b_sof", 32'(ifb.out_sof), 32'(p == 0));
            check("b_eol", 32'(ifb.out_eol), 32'(p == 3));
            check("b_eof", 32'(ifb.out_eof), 32'(p == 3));
            check("b_data", 32'(ifb.lb_wdata), 32'(p + 1));
        end
        @(posedge clk); #2;
        start_b = 1'b0;
        check("b_done", 32'(done_b), 32'd1);
        check("b_done_rdy", 32'(ifb.in_ready), 32'd0);
        check("b_done_valid", 32'(ifb.out_valid), 32'd0);
        @(posedge clk); #2;
        check("b_after_busy", 32'(busy_b), 32'd0);
        check("b_after_done", 32'(done_b), 32'd0);
        ifb.in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
